// File: rtl/divcfg_pkg.sv
// Shared types and constants for the divider configuration sequencer.
// The optional status outputs are enabled with the DIVCFG_STATUS_EN macro.
package divcfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DISABLE = 3'd1,
        ST_LOAD    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RUN     = 3'd4
    } state_e;

    localparam int SETTLE_W  = 4;
    localparam int CFG_CNT_W = 8;
    localparam logic [CFG_CNT_W-1:0] CFG_CNT_MAX = 8'd255;

    function automatic logic [CFG_CNT_W-1:0] sat_inc(input logic [CFG_CNT_W-1:0] v);
        logic [CFG_CNT_W-1:0] r;
        if (v == CFG_CNT_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/divcfg_settle_timer.sv
// Down-counter timing the DISABLE and HOLD settle windows.
// done pulses during the last cycle of a window started with load_val.
module divcfg_settle_timer
    import divcfg_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                start,
    output logic                done
);

    localparam logic [SETTLE_W-1:0] CNT_ONE  = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0] CNT_ZERO = SETTLE_W'(0);

    logic [SETTLE_W-1:0] cnt_d;
    logic [SETTLE_W-1:0] cnt_q;

    // Next count: reload on start, otherwise count down to zero and stop.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = load_val;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_ONE);

endmodule

// File: rtl/divider_config_sequencer.sv
// Safely reprograms a downstream frequency divider: disable, settle, load, settle, run.
// Define DIVCFG_STATUS_EN to add the CurDiv / CfgCount status outputs.
module divider_config_sequencer
    import divcfg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] ReqDiv,
    input  logic        ReqRun,
    output logic [31:0] Din,
    output logic        ConfigDiv,
    output logic        Enable,
    output logic        Busy,
    output logic        Error
`ifdef DIVCFG_STATUS_EN
    ,
    output logic [31:0]          CurDiv,
    output logic [CFG_CNT_W-1:0] CfgCount
`endif
);

    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);

    state_e      state_d, state_q;
    logic [31:0] div_d, div_q;
    logic        run_d, run_q;
    logic [31:0] din_d, din_q;
    logic        cfg_d, cfg_q;
    logic        en_d, en_q;
    logic        busy_d, busy_q;
    logic        err_d, err_q;
    logic        acc_s;
    logic        acc_nz_s;
    logic        tmr_start_s;
    logic        tmr_done_s;

    assign ReqReady    = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign acc_s       = ReqValid && ReqReady;
    assign acc_nz_s    = acc_s && (ReqDiv != 32'd0);
    assign tmr_start_s = acc_nz_s || (state_q == ST_LOAD);

    divcfg_settle_timer u_timer (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .load_val (SETTLE_LD),
        .start    (tmr_start_s),
        .done     (tmr_done_s)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero divisor is rejected without leaving IDLE/RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (acc_nz_s) state_d = ST_DISABLE;
                else          state_d = state_q;
            end
            ST_DISABLE: begin
                if (tmr_done_s) state_d = ST_LOAD;
                else            state_d = ST_DISABLE;
            end
            ST_LOAD: state_d = ST_HOLD;
            ST_HOLD: begin
                if (!tmr_done_s) state_d = ST_HOLD;
                else if (run_q)  state_d = ST_RUN;
                else             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and request-latch next values, decoded from the upcoming state.
    always_comb begin
        div_d  = div_q;
        run_d  = run_q;
        if (acc_nz_s) begin
            div_d = ReqDiv;
            run_d = ReqRun;
        end else begin
            div_d = div_q;
            run_d = run_q;
        end
        if (state_d == ST_LOAD) begin
            din_d = div_q;
        end else begin
            din_d = din_q;
        end
        cfg_d  = (state_d == ST_LOAD);
        en_d   = (state_d == ST_RUN);
        busy_d = (state_d == ST_DISABLE) || (state_d == ST_LOAD) || (state_d == ST_HOLD);
        err_d  = acc_s && (ReqDiv == 32'd0);
    end

    // Output and request-latch registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q  <= 32'd0;
            run_q  <= 1'b0;
            din_q  <= 32'd0;
            cfg_q  <= 1'b0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            run_q  <= run_d;
            din_q  <= din_d;
            cfg_q  <= cfg_d;
            en_q   <= en_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign Din       = din_q;
    assign ConfigDiv = cfg_q;
    assign Enable    = en_q;
    assign Busy      = busy_q;
    assign Error     = err_q;

`ifdef DIVCFG_STATUS_EN
    logic [31:0]          cur_div_d, cur_div_q;
    logic [CFG_CNT_W-1:0] cfg_cnt_d, cfg_cnt_q;

    // Status updates as each LOAD cycle completes.
    always_comb begin
        if (state_q == ST_LOAD) begin
            cur_div_d = din_q;
            cfg_cnt_d = sat_inc(cfg_cnt_q);
        end else begin
            cur_div_d = cur_div_q;
            cfg_cnt_d = cfg_cnt_q;
        end
    end

    // Status registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cur_div_q <= 32'd0;
            cfg_cnt_q <= 8'd0;
        end else begin
            cur_div_q <= cur_div_d;
            cfg_cnt_q <= cfg_cnt_d;
        end
    end

    assign CurDiv   = cur_div_q;
    assign CfgCount = cfg_cnt_q;
`endif

endmodule

// File: doc/divider_config_sequencer.md
DIVIDER_CONFIG_SEQUENCER -- requirements
Module: divider_config_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, legal 1..15: cycles Enable is held low before, and ConfigDiv held low after, a divisor load.
REQ-002 Clk  input  1  single block clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 ReqValid  input  1  new divisor request present.
REQ-005 ReqReady  output  1  sequencer can accept a request.
REQ-006 ReqDiv  input  32  requested divide ratio.
REQ-007 ReqRun  input  1  1 = enable the divider after load; 0 = load and leave stopped.
REQ-008 Din  output  32  divisor driven to the downstream frequency divider.
REQ-009 ConfigDiv  output  1  one-cycle load strobe to the downstream divider.
REQ-010 Enable  output  1  run enable to the downstream divider.
REQ-011 Busy  output  1  reconfiguration sequence in progress.
REQ-012 Error  output  1  one-cycle pulse: request rejected.

Function
REQ-013 The FSM states SHALL be IDLE, DISABLE, LOAD, HOLD and RUN.
REQ-014 ReqReady SHALL be 1 in IDLE and RUN and 0 in DISABLE, LOAD and HOLD; a request is accepted on an edge where ReqValid&ReqReady=1.
REQ-015 An accepted request with ReqDiv=0 SHALL be rejected: Error=1 for exactly the next cycle, no state change, and Din/Enable unchanged.
REQ-016 An accepted nonzero request SHALL latch ReqDiv and ReqRun and move to DISABLE next cycle; Enable=0 from that cycle on.
REQ-017 DISABLE SHALL last exactly SETTLE_CYCLES cycles, then go to LOAD.
REQ-018 LOAD SHALL last exactly one cycle, with ConfigDiv=1 and Din=latched divisor.
REQ-019 HOLD SHALL last exactly SETTLE_CYCLES cycles with ConfigDiv=0, then go to RUN if latched ReqRun=1, else to IDLE.
REQ-020 Enable SHALL be 1 only in RUN; with SETTLE_CYCLES=S, Enable rises 2S+2 cycles after the accepting edge.
REQ-021 Din SHALL change only on entry to LOAD and hold its value in every other state, including IDLE and RUN.
REQ-022 Busy SHALL be 1 exactly in DISABLE, LOAD and HOLD.
REQ-023 An accepted nonzero request in RUN SHALL restart the sequence from DISABLE; the new divisor is never presented while Enable=1.
REQ-024 ReqValid while ReqReady=0 SHALL be ignored; the requester holds it until accepted.
REQ-025 ConfigDiv and Enable SHALL never be 1 in the same cycle.

Reset
REQ-026 Assertion of Reset_n=0 SHALL immediately force: state IDLE, Din=0, ConfigDiv=0, Enable=0, Busy=0, Error=0, settle counter 0, latched ReqRun 0, regardless of current state.
REQ-027 ReqReady SHALL be 1 from the first cycle after Reset_n deasserts; a reset mid-sequence abandons the load and leaves Din=0.

Configuration
REQ-028 With macro DIVCFG_STATUS_EN defined, outputs CurDiv (32, divisor of the last completed LOAD, reset 0) and CfgCount (8, count of completed LOADs, saturating at 255, reset 0) SHALL exist.
REQ-029 Without DIVCFG_STATUS_EN, these ports and their registers SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package divcfg_pkg SHALL hold the FSM state enum, the SETTLE_CYCLES width constant (4 bits) and the CfgCount width/saturation constant.
REQ-031 Sub-module divcfg_settle_timer (load value, start, done pulse) SHALL implement the DISABLE/HOLD down-counter; the FSM and the output registers stay in the top module.

Verification
REQ-032 S=2, ReqDiv=10, ReqRun=1 accepted at edge 0 -> ConfigDiv=1 and Din=10 in cycle 3 only; Enable=1 from cycle 6; Busy=1 in cycles 1-5.
REQ-033 In RUN with Din=10, request ReqDiv=4 -> Enable falls the next cycle; ConfigDiv with Din=4 two cycles later; Enable high again 6 cycles after acceptance.
REQ-034 ReqDiv=0 from IDLE -> Error=1 for one cycle; Din, Enable and state unchanged; ReqReady stays 1.
REQ-035 ReqDiv=7, ReqRun=0 -> after LOAD, FSM returns to IDLE with Din=7, Enable=0.
REQ-036 Reset_n pulsed low during HOLD -> all outputs go to reset values asynchronously; ReqReady=1 the cycle after release.
REQ-037 With DIVCFG_STATUS_EN: 257 successful loads -> CfgCount=255 and CurDiv equals the last divisor; without the macro, the bench compiles without these ports.
